// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner
// Walks every OAM entry once per scanline and collects the indices of the
// visible sprites that cover line sy into a fixed-size slot list, lowest OAM
// index first. OAM is read through a synchronous port with one cycle of latency.
//
// Build option: define SPRITE_OVERFLOW_DETECT_EN to scan all entries and flag
// lines with more sprites than slots. Without it, overflow is tied low and the
// scan stops as soon as the last slot is filled.
module sprite_line_scanner #(
   parameter int MAX_PER_LINE = 32,
   parameter int OAM_OBJECTS  = 256,
   parameter int SPRITE_H     = 16,
   parameter int Y_W          = 10,
   localparam int IDX_W       = $clog2(OAM_OBJECTS),
   localparam int CNT_W       = $clog2(MAX_PER_LINE + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [Y_W-1:0]   sy,
   output logic [IDX_W-1:0] oam_addr,
   input  logic [31:0]      oam_data,
   output logic [IDX_W:0]   BufferArray [MAX_PER_LINE],
   output logic [CNT_W-1:0] obj_count,
   output logic             line_prepared,
   output logic             busy,
   output logic             overflow
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(OAM_OBJECTS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_PER_LINE);
   localparam logic [Y_W:0]     H_LIM     = (Y_W + 1)'(SPRITE_H);

   state_t           state;
   state_t           state_next;
   logic             clear;        // start seen: wipe the list and restart the walk
   logic [Y_W-1:0]   sy_q;         // line being scanned, captured at start
   logic             rd_pending;   // oam_data this cycle answers an address we issued
   logic [IDX_W-1:0] rd_idx;       // OAM index that oam_data belongs to
   logic             issue_done;   // last address has been issued
   logic [Y_W-1:0]   dy;           // distance from sprite top to the line, modulo 2^Y_W
   logic             eval_en;
   logic             hit;
   logic             last_eval;
   logic             early_full;
   logic             unused_oam_bits;

   // Only the visible bit and the Y field of the OAM word matter here.
   assign unused_oam_bits = ^oam_data[30:Y_W];

   // Hit test: the subtraction wraps in Y_W bits, so a sprite whose top sits
   // near the bottom of the coordinate space still covers the first lines.
   assign dy        = sy_q - oam_data[Y_W-1:0];
   assign eval_en   = (state == SCAN) && rd_pending;
   assign hit       = eval_en && oam_data[31] && ({1'b0, dy} < H_LIM);
   assign last_eval = eval_en && (rd_idx == LAST_IDX);

   // State register.
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and status outputs; start overrides whatever is in flight.
   // NOTE: every signal written here gets a default first, otherwise paths
   // that skip an assignment would infer latches.
   always_comb begin
      state_next    = state;
      clear         = 1'b0;
      busy          = 1'b0;
      line_prepared = 1'b0;
      case (state)
         IDLE: begin
            state_next = IDLE;
         end
         SCAN: begin
            busy = 1'b1;
            if (last_eval || early_full) begin
               state_next = DONE;
            end
         end
         DONE: begin
            line_prepared = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (start) begin
         state_next = SCAN;
         clear      = 1'b1;
      end
   end

   // Address generator: one OAM address per SCAN cycle, holding at the last
   // one, with a one-deep tag of which index the returning data belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         oam_addr   <= '0;
         rd_idx     <= '0;
         rd_pending <= 1'b0;
         issue_done <= 1'b0;
         sy_q       <= '0;
      end else if (clear) begin
         oam_addr   <= '0;
         rd_idx     <= '0;
         rd_pending <= 1'b0;
         issue_done <= 1'b0;
         sy_q       <= sy;
      end else if ((state == SCAN) && !issue_done) begin
         rd_pending <= 1'b1;
         rd_idx     <= oam_addr;
         if (oam_addr == LAST_IDX) begin
            issue_done <= 1'b1;
         end else begin
            oam_addr <= oam_addr + 1'b1;
         end
      end else begin
         rd_pending <= 1'b0;
      end
   end

   // Sprite list: each hit lands in the next free slot, so slot order follows
   // OAM order. Writes happen only on a hit, which only exists in SCAN.
   // NOTE: the slot array is a port-visible register bank rather than a RAM,
   // so it is cleared on reset; unused slots must read as zero.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < MAX_PER_LINE; i++) begin
            BufferArray[i] <= '0;
         end
         obj_count <= '0;
      end else if (hit && (obj_count != FULL_CNT)) begin
         for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (obj_count == CNT_W'(i)) begin
               BufferArray[i] <= {rd_idx, 1'b1};
            end
         end
         obj_count <= obj_count + 1'b1;
      end
   end

`ifdef SPRITE_OVERFLOW_DETECT_EN
   logic overflow_q;

   // Sticky overflow: a hit that finds every slot taken.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         overflow_q <= 1'b0;
      end else if (hit && (obj_count == FULL_CNT)) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow   = overflow_q;
   assign early_full = 1'b0;
`else
   // Without overflow detection there is nothing to learn once the list is
   // full, so the hit that fills the last slot ends the scan.
   assign overflow   = 1'b0;
   assign early_full = hit && (obj_count == CNT_W'(MAX_PER_LINE - 1));
`endif

endmodule

// File: tb/tb_sprite_line_scanner.sv
// tb_sprite_line_scanner
// Directed scanline scenarios against a behavioural OAM and an expected-list
// scoreboard. Honours SPRITE_OVERFLOW_DETECT_EN for overflow/done expectations.
module tb_sprite_line_scanner;

   localparam int MAX = 32;
   localparam int N   = 256;
   localparam int H   = 16;
   localparam int YW  = 10;
   localparam int IW  = 8;
   localparam int CW  = 6;

   typedef logic [MAX-1:0][IW:0] list_t;

   typedef struct packed {
      list_t         list;
      logic [CW-1:0] cnt;
      logic          ovf;
      logic [31:0]   done_cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [YW-1:0] sy;
   logic [IW-1:0] oam_addr;
   logic [31:0]   oam_data;
   logic [IW:0]   buf_arr [MAX];
   logic [CW-1:0] obj_count;
   logic          line_prepared;
   logic          busy;
   logic          overflow;

   logic [31:0]   mem [N];
   list_t         got_list;
   exp_t          sb [$];
   int            checks = 0;
   int            errors = 0;

   sprite_line_scanner #(
      .MAX_PER_LINE(MAX),
      .OAM_OBJECTS (N),
      .SPRITE_H    (H),
      .Y_W         (YW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .sy           (sy),
      .oam_addr     (oam_addr),
      .oam_data     (oam_data),
      .BufferArray  (buf_arr),
      .obj_count    (obj_count),
      .line_prepared(line_prepared),
      .busy         (busy),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   // Synchronous OAM: data for an address appears one cycle later.
   always @(posedge clk) oam_data <= mem[oam_addr];

   always_comb begin
      for (int i = 0; i < MAX; i++) got_list[i] = buf_arr[i];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_list(input string tag, input list_t obs, input list_t exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference: walk OAM in order, fill slots, note overflow / early finish.
   function automatic exp_t model(input logic [YW-1:0] s);
      exp_t          e;
      logic [YW-1:0] d;
      int            n;
      e          = '0;
      n          = 0;
      e.done_cyc = 32'(N + 2);
      for (int i = 0; i < N; i++) begin
         d = s - mem[i][YW-1:0];
         if (mem[i][31] && (d < YW'(H))) begin
            if (n < MAX) begin
               e.list[n] = {IW'(i), 1'b1};
               n++;
`ifndef SPRITE_OVERFLOW_DETECT_EN
               if (n == MAX) begin
                  e.done_cyc = 32'(i + 3);
                  break;
               end
`endif
            end else begin
               e.ovf = 1'b1;
            end
         end
      end
      e.cnt = CW'(n);
      return e;
   endfunction

   task automatic fill_all(input logic [31:0] w);
      for (int i = 0; i < N; i++) mem[i] = w;
   endtask

   // Called at a negedge; pulses start for one cycle and checks cycle 1.
   task automatic pulse_start(input logic [YW-1:0] s, input string tag);
      sb.push_back(model(s));
      sy    = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sy    = ~s;
      chk({tag, " c1 busy"}, 64'(busy), 64'd1);
      chk({tag, " c1 prepared"}, 64'(line_prepared), 64'd0);
      chk({tag, " c1 count"}, 64'(obj_count), 64'd0);
      chk({tag, " c1 addr"}, 64'(oam_addr), 64'd0);
      chk({tag, " c1 overflow"}, 64'(overflow), 64'd0);
      chk_list({tag, " c1 list"}, got_list, '0);
   endtask

   // Entered at cycle 1 of a scan; waits for line_prepared and scores it.
   task automatic wait_done(input string tag);
      exp_t e;
      int   cyc;
      bit   seen;
      cyc  = 1;
      seen = 1'b0;
      while (cyc < 600) begin
         if (line_prepared) begin
            seen = 1'b1;
            break;
         end
         if (cyc == 10) chk({tag, " addr c10"}, 64'(oam_addr), 64'd9);
         @(negedge clk);
         cyc++;
      end
      chk({tag, " done seen"}, 64'(seen), 64'd1);
      if (!seen || sb.size() == 0) begin
         sb.delete();
         return;
      end
      e = sb.pop_front();
      chk({tag, " done cycle"}, 64'(cyc), 64'(e.done_cyc));
      chk_list({tag, " list"}, got_list, e.list);
      chk({tag, " count"}, 64'(obj_count), 64'(e.cnt));
      chk({tag, " overflow"}, 64'(overflow), 64'(e.ovf));
      chk({tag, " busy"}, 64'(busy), 64'd0);
      repeat (5) @(negedge clk);
      chk_list({tag, " frozen list"}, got_list, e.list);
      chk({tag, " still prepared"}, 64'(line_prepared), 64'd1);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      sy    = '0;
      fill_all(32'h0);
      repeat (3) @(negedge clk);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst prepared", 64'(line_prepared), 64'd0);
      chk("rst count", 64'(obj_count), 64'd0);
      chk("rst addr", 64'(oam_addr), 64'd0);
      chk("rst overflow", 64'(overflow), 64'd0);
      chk_list("rst list", got_list, '0);
      reset = 1'b0;
      @(negedge clk);

      // Empty OAM.
      pulse_start(10'd0, "empty");
      wait_done("empty");
      chk("empty count const", 64'(obj_count), 64'd0);

      // Every entry visible at y=0.
      fill_all(32'h8000_0000);
      pulse_start(10'd0, "full");
      wait_done("full");
      chk("full slot31", 64'(got_list[31]), 64'({8'd31, 1'b1}));
      chk("full count const", 64'(obj_count), 64'd32);

      // Two sprites; then the same pair on a line only one covers.
      fill_all(32'h0);
      mem[5] = 32'h8000_0000 | 32'd100;
      mem[9] = 32'h8000_0000 | 32'd110;
      pulse_start(10'd112, "pair112");
      wait_done("pair112");
      chk("pair112 slot0", 64'(got_list[0]), 64'({8'd5, 1'b1}));
      chk("pair112 slot1", 64'(got_list[1]), 64'({8'd9, 1'b1}));
      pulse_start(10'd116, "pair116");
      wait_done("pair116");
      chk("pair116 slot0", 64'(got_list[0]), 64'({8'd9, 1'b1}));
      chk("pair116 count", 64'(obj_count), 64'd1);

      // Sprite wrapping past line 0.
      fill_all(32'h0);
      mem[3] = 32'h8000_0000 | 32'd1020;
      pulse_start(10'd4, "wrap4");
      wait_done("wrap4");
      chk("wrap4 slot0", 64'(got_list[0]), 64'({8'd3, 1'b1}));
      pulse_start(10'd12, "wrap12");
      wait_done("wrap12");
      chk("wrap12 count", 64'(obj_count), 64'd0);

      // Reset at cycle 50 of a scan, then a clean full scan.
      fill_all(32'h8000_0000);
      pulse_start(10'd0, "rstmid");
      repeat (49) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid busy", 64'(busy), 64'd0);
      chk("rstmid prepared", 64'(line_prepared), 64'd0);
      chk("rstmid count", 64'(obj_count), 64'd0);
      chk("rstmid addr", 64'(oam_addr), 64'd0);
      chk("rstmid overflow", 64'(overflow), 64'd0);
      chk_list("rstmid list", got_list, '0);
      reset = 1'b0;
      sb.delete();
      @(negedge clk);
      pulse_start(10'd0, "after_rst");
      wait_done("after_rst");

      // Restart at cycle 100 of a scan.
      fill_all(32'h0);
      mem[5] = 32'h8000_0000 | 32'd100;
      mem[9] = 32'h8000_0000 | 32'd110;
      pulse_start(10'd112, "restart_a");
      repeat (99) @(negedge clk);
      chk("restart c100 count", 64'(obj_count), 64'd2);
      chk("restart c100 prepared", 64'(line_prepared), 64'd0);
      sb.delete();
      pulse_start(10'd116, "restart_b");
      wait_done("restart_b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_line_scanner.md
SPRITE_LINE_SCANNER -- requirements
Module: sprite_line_scanner

Interface
REQ-001 SHALL have parameter MAX_PER_LINE, 32, number of sprite slots per scanline (1..64).
REQ-002 SHALL have parameter OAM_OBJECTS, 256, number of OAM entries scanned (power of 2, 2..1024).
REQ-003 SHALL have parameter SPRITE_H, 16, sprite height in lines (1..64).
REQ-004 SHALL have parameter Y_W, 10, width of the line and sprite-Y coordinates.
REQ-005 SHALL define IDX_W = $clog2(OAM_OBJECTS) and CNT_W = $clog2(MAX_PER_LINE+1).
REQ-006 SHALL have port clk  in  1  the one clock; all logic is on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse that begins a scan for line sy.
REQ-009 SHALL have port sy  in  Y_W  target scanline, sampled only on the cycle start is high.
REQ-010 SHALL have port oam_addr  out  IDX_W  OAM read address.
REQ-011 SHALL have port oam_data  in  32  OAM word; [31] visible, [Y_W-1:0] sprite top Y; valid one cycle after oam_addr.
REQ-012 SHALL have port BufferArray  out  MAX_PER_LINE x (IDX_W+1)  sprite list; entry[0] valid, entry[IDX_W:1] OAM index.
REQ-013 SHALL have port obj_count  out  CNT_W  number of valid entries.
REQ-014 SHALL have port line_prepared  out  1  high while the list is complete and stable.
REQ-015 SHALL have port busy  out  1  high while a scan is in progress.
REQ-016 SHALL have port overflow  out  1  more than MAX_PER_LINE sprites hit the line.

Function
REQ-017 SHALL implement states IDLE, SCAN, DONE; start in any state moves to SCAN (an in-progress scan is aborted and restarted).
REQ-018 SHALL, on the cycle after start (cycle 1), hold every BufferArray entry at 0, obj_count=0, overflow=0, line_prepared=0, busy=1, oam_addr=0.
REQ-019 SHALL increment oam_addr by one each SCAN cycle from 0 to OAM_OBJECTS-1 and hold it after the last address.
REQ-020 SHALL evaluate the oam_data returned for address k on cycle k+2 (1-cycle OAM read latency).
REQ-021 SHALL declare a hit when oam_data[31]=1 and ((sy - y) mod 2^Y_W) < SPRITE_H, computed in Y_W bits so sprites wrapping past line 0 are hits.
REQ-022 SHALL write each hit to slot obj_count as {index,1'b1} and increment obj_count, so lower OAM indices occupy lower slots.
REQ-023 SHALL, on a hit with obj_count == MAX_PER_LINE, leave the list unchanged and set overflow (sticky until next start).
REQ-024 SHALL, after the last entry is evaluated (cycle OAM_OBJECTS+1), enter DONE on the next cycle: line_prepared=1, busy=0, list frozen until next start or reset.
REQ-025 SHALL keep unused slots at 0 and never change BufferArray in IDLE or DONE.
REQ-026 SHALL ignore sy changes after the start cycle for the rest of the scan.

Reset
REQ-027 SHALL, while reset is high, force IDLE, BufferArray all 0, obj_count=0, oam_addr=0, line_prepared=0, busy=0, overflow=0.
REQ-028 SHALL give reset priority over start in the same cycle; a reset mid-scan discards the partial list.

Configuration
REQ-029 SHALL honour macro SPRITE_OVERFLOW_DETECT_EN.
REQ-030 SHALL, with SPRITE_OVERFLOW_DETECT_EN defined, scan all OAM_OBJECTS entries and drive overflow per REQ-023.
REQ-031 SHALL, without SPRITE_OVERFLOW_DETECT_EN, tie overflow to 0 and enter DONE on the cycle after the hit that makes obj_count == MAX_PER_LINE (early exit).

Verification
REQ-032 SHALL verify: all oam_data=0, start, sy=0 -> line_prepared at cycle OAM_OBJECTS+2, BufferArray all 0, obj_count=0.
REQ-033 SHALL verify: all entries visible, y=0, sy=0 -> slot i = {i,1}, i=0..31, obj_count=32; overflow=1 with macro (done at cycle 258), done at cycle 34 without.
REQ-034 SHALL verify: only entries 5 (y=100) and 9 (y=110) visible, sy=112 -> slot0={5,1}, slot1={9,1}, obj_count=2; sy=116 -> only {9,1}.
REQ-035 SHALL verify wrap: entry 3 visible with y=1020, SPRITE_H=16, sy=4 -> slot0={3,1}; sy=12 -> empty list.
REQ-036 SHALL verify: start, reset asserted at cycle 50 -> all outputs reset next cycle; new start at sy=0 (as REQ-033) produces full correct list.
REQ-037 SHALL verify: second start at cycle 100 of a scan -> list cleared, scan restarts, line_prepared only after the second scan completes.
